pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised chain of NUM_STAGES pipeline registers (payload + valid) with valid/ready handshake,
//  per-stage stall (bubble insertion) and per-stage flush. Successor to the fixed IF/ID, ID/EX, EX/MEM
//  registers: one instance per inter-stage boundary group, driven by the hazard/branch logic in the
//  pipelined core top.
// PARAMETERS
//  WIDTH       32  payload bits per stage (packed control + data fields)
//  NUM_STAGES  4   register stages in the chain; >=1
// PORTS
//  clk         in   1                 single clock, rising edge
//  rst_n       in   1                 asynchronous, active-low reset
//  in_valid    in   1                 upstream payload valid
//  in_ready    out  1                 chain accepts in_data this cycle
//  in_data     in   WIDTH             upstream payload
//  out_valid   out  1                 last stage holds a releasable payload
//  out_ready   in   1                 downstream accepts
//  out_data    out  WIDTH             last-stage payload
//  stall       in   NUM_STAGES        stall[i]: stage i holds, sends bubble to i+1
//  flush       in   NUM_STAGES        flush[i]: invalidate stage i at next edge
//  occupancy   out  $clog2(NUM_STAGES+1)  count of valid stages (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all valid[i]=0, data[i]=0, occupancy=0, skid empty; outputs low/zero.
//  - ready[N]=out_ready; ready[i] = !stall[i] && (!valid[i] || ready[i+1]) (combinational chain).
//  - Advance i->i+1 when valid[i] && !stall[i] && ready[i+1]; in_ready=ready[0] (no skid).
//  - Stage i at edge: if flush[i] -> valid=0 (priority over everything); else if ready[i] -> load
//    valid/data from i-1 (valid forced 0 if i-1 stalled = bubble); else hold.
//  - data[i] updates only when a valid payload loads; bubbles/flush leave data unchanged.
//  - out_valid = valid[N-1] && !stall[N-1]; out_data = data[N-1].
//  - Flush evaluated on current-cycle ready; an accepted in_data landing in a flushed stage 0 is dropped.
//  - Latency: accept at edge k -> out_valid from edge k+NUM_STAGES-1 onward when unstalled (one stage
//    per cycle); full throughput 1/cycle with out_ready=1.
//  - Full: all valid and out_ready=0 -> in_ready=0, contents hold. Empty: out_valid=0.
//  - occupancy = popcount(next valid) registered each edge.
//  - Reset mid-operation discards all in-flight payloads; no partial state retained.
// CONFIGURATION
//  PIPE_SKID_EN defined: 2-entry skid buffer (pipe_skid_buffer) inserted before stage 0; in_ready is
//   registered (=skid not full), cuts the combinational ready chain from upstream; +1 cycle latency;
//   flush[0] also empties the skid; skid entries not counted in occupancy.
//  PIPE_SKID_EN undefined: in_ready = ready[0] combinational, no extra latency.
// STRUCTURE
//  - Shared package pipe_pkg: payload field offsets/width localparams for IF/ID, ID/EX, EX/MEM packing;
//    typedef pipe_stage_t {valid, data}.
//  - Sub-module pipe_skid_buffer (WIDTH param) only under PIPE_SKID_EN; stage chain is a generate loop.
// TESTING (WIDTH=32, NUM_STAGES=4, no skid unless stated)
//  1 Stream 0x1..0x8, out_ready=1 -> out_data 0x1..0x8 in order, one per cycle, 4-cycle latency.
//  2 Fill with 0xA..0xD, out_ready=0 -> in_ready=0, occupancy=4, data held; release -> drains in order.
//  3 stall=4'b0001 one cycle mid-stream -> stage0 holds, one bubble reaches output, no payload lost.
//  4 flush=4'b0011 with stages full -> next cycle occupancy=2, flushed payloads never appear at out.
//  5 rst_n low mid-stream -> out_valid=0, occupancy=0 immediately; resume -> clean restart.
//  6 PIPE_SKID_EN: out_ready=0, push 6 words -> in_ready drops after 6 accepted; all 6 emerge, +1 latency.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers.
// Holds payload field layouts for the IF/ID, ID/EX and EX/MEM boundaries and the
// generic stage record used by the core top when it unpacks a stage.
package pipe_pkg;

    localparam int PIPE_WIDTH      = 32;

    // IF/ID payload: {instr[15:0], pc[15:0]}
    localparam int IFID_PC_LSB     = 0;
    localparam int IFID_PC_W       = 16;
    localparam int IFID_INSTR_LSB  = 16;
    localparam int IFID_INSTR_W    = 16;

    // ID/EX payload: {ctrl[7:0], rs_val[15:0], rd[7:0]}
    localparam int IDEX_RD_LSB     = 0;
    localparam int IDEX_RD_W       = 8;
    localparam int IDEX_RS_LSB     = 8;
    localparam int IDEX_RS_W       = 16;
    localparam int IDEX_CTRL_LSB   = 24;
    localparam int IDEX_CTRL_W     = 8;

    // EX/MEM payload: {wb_ctrl[7:0], result[23:0]}
    localparam int EXMEM_RES_LSB   = 0;
    localparam int EXMEM_RES_W     = 24;
    localparam int EXMEM_CTRL_LSB  = 24;
    localparam int EXMEM_CTRL_W    = 8;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_WIDTH-1:0] data;
    } pipe_stage_t;

    // Builds an IF/ID payload from its fields.
    function automatic logic [PIPE_WIDTH-1:0] pack_ifid(
        input logic [IFID_PC_W-1:0]    pc,
        input logic [IFID_INSTR_W-1:0] instr
    );
        return {instr, pc};
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer placed in front of stage 0 when PIPE_SKID_EN is defined.
// in_ready comes straight from the entry count register, so the upstream never
// sees the combinational ready chain of the stages. clear empties both entries
// and drops any word pushed in the same cycle.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Entry storage, pointers and fill count; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of NUM_STAGES payload+valid registers with valid/ready handshake,
// per-stage stall (stage holds, next stage receives a bubble) and per-stage flush.
// Optional feature macro: PIPE_SKID_EN adds a registered-ready skid buffer ahead
// of stage 0 (one extra cycle of latency, skid entries not in occupancy).
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  out_data,
    input  logic [NUM_STAGES-1:0]             stall,
    input  logic [NUM_STAGES-1:0]             flush,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES:0]   ready;
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] src_valid;
    logic [NUM_STAGES-1:0] valid_nxt;
    logic [NUM_STAGES-1:0] load;
    logic [WIDTH-1:0]      data_q   [NUM_STAGES];
    logic [WIDTH-1:0]      src_data [NUM_STAGES];
    logic                  head_valid;
    logic [WIDTH-1:0]      head_data;

`ifdef PIPE_SKID_EN
    pipe_skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush[0]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (head_valid),
        .out_ready (ready[0]),
        .out_data  (head_data)
    );
`else
    assign in_ready   = ready[0];
    assign head_valid = in_valid;
    assign head_data  = in_data;
`endif

    // Ready ripples from the output back to stage 0 within one block.
    always_comb begin
        ready             = '0;
        ready[NUM_STAGES] = out_ready;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            ready[i] = !stall[i] && (!valid_q[i] || ready[i + 1]);
        end
    end

    // Per-stage source selection and next valid; a stalled predecessor offers a bubble.
    always_comb begin
        src_valid    = '0;
        src_data[0]  = head_data;
        src_valid[0] = head_valid;
        for (int i = 1; i < NUM_STAGES; i++) begin
            src_valid[i] = valid_q[i - 1] && !stall[i - 1];
            src_data[i]  = data_q[i - 1];
        end
        valid_nxt = '0;
        load      = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (flush[i]) begin
                valid_nxt[i] = 1'b0;
            end else if (ready[i]) begin
                valid_nxt[i] = src_valid[i];
                load[i]      = src_valid[i];
            end else begin
                valid_nxt[i] = valid_q[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        logic             v_q;
        logic [WIDTH-1:0] d_q;

        // Stage register: valid follows the next-state, data only on a real load.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else begin
                v_q <= valid_nxt[g];
                if (load[g]) begin
                    d_q <= src_data[g];
                end
            end
        end

        assign valid_q[g] = v_q;
        assign data_q[g]  = d_q;
    end

    // Occupancy tracks the number of valid stages after each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= OCC_W'($countones(valid_nxt));
        end
    end

    assign out_valid = valid_q[NUM_STAGES - 1] && !stall[NUM_STAGES - 1];
    assign out_data  = data_q[NUM_STAGES - 1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (WIDTH=32, NUM_STAGES=4).
`timescale 1ns/1ps
module tb_pipe_stage_chain;

    localparam int NS = 4;
`ifdef PIPE_SKID_EN
    localparam int EXTRA_LAT = 1;
`else
    localparam int EXTRA_LAT = 0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_data   = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  stall     = '0;
    logic [3:0]  flush     = '0;
    logic [2:0]  occupancy;

    pipe_stage_chain #(.WIDTH(32), .NUM_STAGES(NS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   out_cnt   = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    bit   lat_check = 1'b0;

    always @(posedge clk) cyc++;

    // Expected responses enter the queue when the chain accepts a word.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready && !flush[0])
            exp_q.push_back('{data: in_data, cyc: cyc});
    end

    // Monitor: every released output is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %08h, required no output", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL out_data: got %08h, required %08h", out_data, mon_e.data);
                end
                if (lat_check) begin
                    checks++;
                    if (cyc - mon_e.cyc != NS + EXTRA_LAT) begin
                        errors++;
                        $display("FAIL latency: got %0d, required %0d", cyc - mon_e.cyc, NS + EXTRA_LAT);
                    end
                end
            end
            if (out_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            out_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Present one word (caller is just after a rising edge) and hold until accepted.
    task automatic send_word(input logic [31:0] w);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %08h got in_ready=0, required 1", w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words left, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_in_ready",  32'(in_ready), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: streaming, one per cycle, fixed latency
        out_ready = 1'b1;
        lat_check = 1'b1;
        out_cnt   = 0;
        for (int i = 1; i <= 8; i++) send_word(32'(i));
        in_valid = 1'b0;
        wait_drain();
        lat_check = 1'b0;
        chk("t1_count", out_cnt, 8);
        chk("t1_span",  last_cyc - first_cyc, 7);

        // 2: fill with output blocked, hold, then release
        out_ready = 1'b0;
        send_word(32'h0000_000A);
        send_word(32'h0000_000B);
        send_word(32'h0000_000C);
        send_word(32'h0000_000D);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t2_in_ready",  32'(in_ready), EXTRA_LAT);
        chk("t2_occupancy", 32'(occupancy), 4);
        chk("t2_out_valid", 32'(out_valid), 1);
        chk("t2_head_data", out_data, 32'h0000_000A);
        out_cnt   = 0;
        out_ready = 1'b1;
        wait_drain();
        chk("t2_count", out_cnt, 4);
        chk("t2_empty_valid", 32'(out_valid), 0);
        chk("t2_empty_occ",   32'(occupancy), 0);

        // 3: single-cycle stall of stage 0 mid-stream
        out_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_word(32'h30 + 32'(i));
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                stall = 4'b0001;
                @(posedge clk);
                #1;
                stall = 4'b0000;
            end
        join
        wait_drain();
        chk("t3_count", out_cnt, 6);
        chk("t3_span",  last_cyc - first_cyc, 6);

        // 4: flush the two youngest stages of a full chain
        out_ready = 1'b0;
        send_word(32'h40);
        send_word(32'h41);
        send_word(32'h42);
        send_word(32'h43);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t4_full_occ", 32'(occupancy), 4);
        flush = 4'b0011;
        @(posedge clk);
        #1;
        flush = 4'b0000;
        chk("t4_flush_occ", 32'(occupancy), 2);
        chk("t4_head_data", out_data, 32'h40);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        out_cnt   = 0;
        out_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        chk("t4_count", out_cnt, 2);
        chk("t4_end_occ", 32'(occupancy), 0);

        // 5: asynchronous reset mid-stream, then clean restart
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h50 + 32'(i);
            @(posedge clk);
            #1;
        end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 0);
        chk("t5_rst_occ",       32'(occupancy), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_cnt = 0;
        for (int i = 0; i < 4; i++) send_word(32'h60 + 32'(i));
        in_valid = 1'b0;
        wait_drain();
        chk("t5_restart_count", out_cnt, 4);

`ifdef PIPE_SKID_EN
        // 6: skid absorbs two extra words beyond the four stages
        begin
            int n;
            n         = 0;
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1;
                in_data  = 32'h70 + 32'(n);
                @(negedge clk);
                if (in_ready) n++;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            chk("t6_accepted", n, 6);
            chk("t6_in_ready", 32'(in_ready), 0);
            out_cnt   = 0;
            out_ready = 1'b1;
            wait_drain();
            chk("t6_count", out_cnt, 6);
        end
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
